// File: rtl/aes_inv_cipher_ctrl_if.sv
// Handshake, key-store and result bundle for aes_inv_cipher_ctrl.
// slave = the cipher controller; master = upstream source, key store and downstream sink.
interface aes_inv_cipher_ctrl_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] ciphertext;
   logic [3:0]   rk_idx;
   logic [127:0] rk;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] plaintext;
   logic         busy;

   modport master (
      output in_valid, ciphertext, rk, out_ready,
      input  in_ready, rk_idx, out_valid, plaintext, busy
   );

   modport slave (
      input  in_valid, ciphertext, rk, out_ready,
      output in_ready, rk_idx, out_valid, plaintext, busy
   );
endinterface

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES-128 decryption controller: one inverse round per cycle over a shared datapath.
// Optional macro AES_INV_SUBBYTE_REG_EN registers InvShiftRows+InvSubBytes (two cycles per round).
module aes_inv_cipher_ctrl (
   input logic                   clk,
   input logic                   rst_n,
   aes_inv_cipher_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} st_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Inverse affine map, then multiplicative inverse as x^254 (maps 0 to 0).
   function automatic logic [7:0] inverse_subbyte(input logic [7:0] s);
      logic [7:0] b;
      logic [7:0] p;
      logic [7:0] inv;
      b   = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
      inv = 8'h01;
      p   = b;
      for (int i = 0; i < 7; i++) begin
         p   = gf_mul(p, p);
         inv = gf_mul(inv, p);
      end
      return inv;
   endfunction

   // FIPS byte k sits at bits [127-8k -: 8]; s[r][c] is byte 4c+r.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a  [4];
      logic [7:0]   x2 [4];
      logic [7:0]   x4 [4];
      logic [7:0]   x8 [4];
      logic [7:0]   m9 [4];
      logic [7:0]   mb [4];
      logic [7:0]   md [4];
      logic [7:0]   me [4];
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            a[r]  = s[127-8*(4*c+r) -: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
            m9[r] = x8[r] ^ a[r];
            mb[r] = x8[r] ^ x2[r] ^ a[r];
            md[r] = x8[r] ^ x4[r] ^ a[r];
            me[r] = x8[r] ^ x4[r] ^ x2[r];
         end
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
         end
      end
      return o;
   endfunction

   st_e          st_q, st_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [127:0] state_q, state_d;

   logic [127:0] isr;
   logic [127:0] isb;
   logic [127:0] ark_in;
   logic [127:0] ark;
   logic [127:0] imc;
   logic         step;

   logic         in_ready;
   logic         out_valid;
   logic         busy;
   logic [3:0]   rk_idx;

   assign isr = inv_shift_rows(state_q);

   for (genvar i = 0; i < 16; i++) begin : g_inverse_subbyte
      assign isb[8*i+7 -: 8] = inverse_subbyte(isr[8*i+7 -: 8]);
   end

`ifdef AES_INV_SUBBYTE_REG_EN
   logic [127:0] sb_q;
   logic         phase_q;
   logic         in_round;

   assign in_round = (st_q == StRound) || (st_q == StFinal);

   // Phase 0 captures the substituted state, phase 1 commits the round.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_q    <= '0;
         phase_q <= 1'b0;
      end else begin
         if (in_round && !phase_q) sb_q <= isb;
         phase_q <= in_round ? ~phase_q : 1'b0;
      end
   end

   assign step   = phase_q;
   assign ark_in = sb_q;
`else
   assign step   = 1'b1;
   assign ark_in = isb;
`endif

   assign ark = ark_in ^ bus.rk;
   assign imc = inv_mix_columns(ark);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q    <= StIdle;
         rnd_q   <= 4'd0;
         state_q <= '0;
      end else begin
         st_q    <= st_d;
         rnd_q   <= rnd_d;
         state_q <= state_d;
      end
   end

   always_comb begin
      st_d      = st_q;
      rnd_d     = rnd_q;
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      rk_idx    = 4'd0;
      unique case (st_q)
         StIdle: begin
            busy     = 1'b0;
            in_ready = 1'b1;
            rk_idx   = 4'd10;
            if (bus.in_valid) begin
               state_d = bus.ciphertext ^ bus.rk;
               rnd_d   = 4'd9;
               st_d    = StRound;
            end
         end
         StRound: begin
            rk_idx = rnd_q;
            if (step) begin
               state_d = imc;
               if (rnd_q == 4'd1) st_d = StFinal;
               else               rnd_d = rnd_q - 4'd1;
            end
         end
         StFinal: begin
            if (step) begin
               state_d = ark;
               st_d    = StDone;
            end
         end
         StDone: begin
            out_valid = 1'b1;
            if (bus.out_ready) st_d = StIdle;
         end
         default: st_d = StIdle;
      endcase
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.busy      = busy;
   assign bus.rk_idx    = rk_idx;
   assign bus.plaintext = state_q;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Directed bench for aes_inv_cipher_ctrl: FIPS vectors, key-index sequence, backpressure,
// back-to-back blocks and asynchronous reset mid-round.
module tb_aes_inv_cipher_ctrl;

`ifdef AES_INV_SUBBYTE_REG_EN
   localparam int H = 2;
`else
   localparam int H = 1;
`endif
   localparam int LAT = 10 * H + 1;

   localparam logic [127:0] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CtC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PtC1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CtB   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PtB   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CtZ   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;
   logic [127:0] ks [0:10];

   aes_inv_cipher_ctrl_if bus ();

   aes_inv_cipher_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.rk = (bus.rk_idx <= 4'd10) ? ks[bus.rk_idx] : '0;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [7:0] r;
      r = (b << n) | (b >> (8 - n));
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv;
      logic [7:0] p;
      inv = 8'h01;
      p   = x;
      for (int i = 0; i < 7; i++) begin
         p   = gmul(p, p);
         inv = gmul(inv, p);
      end
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   task automatic load_key(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
            rcon = gmul(rcon, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int exp_idx(input int k);
      if (k <= 9 * H) return 9 - (k - 1) / H;
      return 0;
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, "_in_ready"},  128'(bus.in_ready),  128'(1));
      chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
      chk({tag, "_busy"},      128'(bus.busy),      128'(0));
      chk({tag, "_rk_idx"},    128'(bus.rk_idx),    128'(10));
   endtask

   // Entered at a negedge in IDLE; returns at the negedge of the first DONE cycle.
   task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input string tag);
      chk({tag, "_accept_ready"}, 128'(bus.in_ready), 128'(1));
      chk({tag, "_accept_idx"},   128'(bus.rk_idx),   128'(10));
      bus.in_valid   = 1'b1;
      bus.ciphertext = ct;
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         if (k == 1) begin
            bus.in_valid   = 1'b0;
            bus.ciphertext = {$urandom, $urandom, $urandom, $urandom};
         end
         if (k < LAT) begin
            chk($sformatf("%s_rk_idx_c%0d", tag, k), 128'(bus.rk_idx), 128'(exp_idx(k)));
            chk($sformatf("%s_no_valid_c%0d", tag, k), 128'(bus.out_valid), 128'(0));
         end
      end
      chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'(1));
      chk({tag, "_plaintext"}, bus.plaintext, pt);
      chk({tag, "_done_idx"},  128'(bus.rk_idx), 128'(0));
   endtask

   task automatic release_done(input string tag);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk_idle({tag, "_after_release"});
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.in_valid   = 1'b0;
      bus.ciphertext = '0;
      bus.out_ready  = 1'b0;
      load_key(KeyC1);

      // Reset values
      repeat (2) @(negedge clk);
      chk_idle("reset");
      chk("reset_plaintext", bus.plaintext, '0);
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle("post_reset");

      // FIPS-197 C.1 with key-index sequence, then 20 cycles of backpressure
      run_block(CtC1, PtC1, "c1");
      for (int i = 0; i < 20; i++) begin
         bus.in_valid   = 1'b1;
         bus.ciphertext = CtB;
         @(negedge clk);
         chk($sformatf("bp_valid_%0d", i), 128'(bus.out_valid), 128'(1));
         chk($sformatf("bp_pt_%0d", i), bus.plaintext, PtC1);
         chk($sformatf("bp_in_ready_%0d", i), 128'(bus.in_ready), 128'(0));
         chk($sformatf("bp_idx_%0d", i), 128'(bus.rk_idx), 128'(0));
      end
      bus.in_valid = 1'b0;
      release_done("bp");

      // All-zero key and plaintext
      load_key('0);
      run_block(CtZ, '0, "zero");
      release_done("zero");

      // Back-to-back with in_valid and out_ready held high; key store swapped while in DONE
      load_key(KeyC1);
      bus.in_valid   = 1'b1;
      bus.ciphertext = CtC1;
      bus.out_ready  = 1'b1;
      for (int k = 1; k <= LAT; k++) @(negedge clk);
      chk("b2b_first_valid", 128'(bus.out_valid), 128'(1));
      chk("b2b_first_pt", bus.plaintext, PtC1);
      chk("b2b_done_no_ready", 128'(bus.in_ready), 128'(0));
      load_key(KeyB);
      bus.ciphertext = CtB;
      @(negedge clk);
      chk("b2b_second_accept", 128'(bus.in_ready), 128'(1));
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         if (k == 1) bus.in_valid = 1'b0;
      end
      chk("b2b_second_valid", 128'(bus.out_valid), 128'(1));
      chk("b2b_second_pt", bus.plaintext, PtB);
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk_idle("b2b_end");

      // Asynchronous reset in cycle 5 of a decryption
      load_key(KeyC1);
      bus.in_valid   = 1'b1;
      bus.ciphertext = CtC1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_busy", 128'(bus.busy), 128'(1));
      #2 rst_n = 1'b0;
      #1;
      chk_idle("mid_reset");
      chk("mid_reset_pt", bus.plaintext, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle("mid_released");
      run_block(CtC1, PtC1, "c1_again");
      release_done("c1_again");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/aes_inv_cipher_ctrl.md
# aes_inv_cipher_ctrl

Iterative AES-128 decryption controller. Accepts one 128-bit ciphertext block, sequences the ten inverse rounds over a single round datapath, and returns the plaintext. The round datapath is InvShiftRows, then the `inverse_subByte` instance, then AddRoundKey, then InvMixColumns. The block sits between the block-level input/output handshakes and an external round-key store, which it indexes one round key per round.

## Interface
Parameters:
- none. The block is fixed at AES-128: Nr = 10, 128-bit state and key.

Ports:
- `clk`  in  1  System clock. All state updates occur on the rising edge.
- `rst_n`  in  1  Reset, asynchronous and active-low.
- `in_valid`  in  1  Ciphertext offered.
- `in_ready`  out  1  Block can accept a ciphertext. High only in IDLE.
- `ciphertext`  in  128  FIPS-197 byte 0 = bits [127:120].
- `rk_idx`  out  4  Round-key index requested from the key store. Range 0..10.
- `rk`  in  128  Round key for `rk_idx`. The key store drives it combinationally in the same cycle.
- `out_valid`  out  1  Plaintext valid.
- `out_ready`  in  1  Downstream accepts the plaintext.
- `plaintext`  out  128  Result, same byte order as `ciphertext`.
- `busy`  out  1  High in every state except IDLE.

## Operation
State mapping:
- `s[r][c]` = FIPS byte 4c+r.
- InvSubBytes is applied bytewise through `inverse_subByte`; byte i = bits [8i+7:8i].

State machine: IDLE → ROUND → FINAL → DONE → IDLE. A 4-bit round counter `rnd` runs with it.
- **IDLE**
  - `rk_idx` = 10; `in_ready` = 1.
  - On `in_valid && in_ready`: state register ← `ciphertext ^ rk`, `rnd` ← 9, go to ROUND.
- **ROUND**
  - `rk_idx` = `rnd`.
  - State register ← InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk).
  - If `rnd` == 1, go to FINAL; otherwise `rnd` ← `rnd` − 1.
- **FINAL**
  - `rk_idx` = 0.
  - State register ← InvSubBytes(InvShiftRows(state)) ^ rk. InvMixColumns is not applied.
  - Go to DONE.
- **DONE**
  - `out_valid` = 1.
  - `plaintext` and `rk_idx` (= 0) are held stable.
  - On `out_ready`: go to IDLE. The next ciphertext can be accepted no earlier than the following cycle.

Arithmetic and datapath rules:
- InvMixColumns multiplies each column by {0e,0b,0d,09} over GF(2^8), reduction polynomial 0x11B, using xtime chains. No lookup tables.
- `plaintext` is the state register output directly. Its value is meaningful only while `out_valid` is high.
- `in_valid` is ignored outside IDLE. `ciphertext` is not sampled after the accept cycle.
- `out_ready` is ignored outside DONE.

## Timing
Reset values:
- State = IDLE, `rnd` = 0, state register = 0.
- `in_ready` = 1, `out_valid` = 0, `busy` = 0, `rk_idx` = 10, `plaintext` = 0.

Latency:
- With the accept edge at cycle 0: ROUND occupies cycles 1..9, FINAL occupies cycle 10.
- `out_valid` rises in cycle 11 (11 cycles accept-to-valid).
- Best-case throughput is one block per 12 cycles, with `out_ready` held high.

Handshake and boundary rules:
- `out_valid` stays high and `plaintext` stays stable until the cycle `out_ready` is sampled high.
- When `in_valid` and `out_ready` are both high in DONE, the input is not accepted in that cycle; `in_ready` is 0 there.
- Reset asserted mid-operation clears the block immediately to reset values. No partial result is emitted.
- `rk` must be stable for the whole cycle in which it is used. The block never registers it.

## Configuration
- `AES_INV_SUBBYTE_REG_EN` defined:
  - Adds a 128-bit pipeline register after InvShiftRows+InvSubBytes.
  - ROUND and FINAL each take 2 cycles: cycle A captures the InvSubBytes result, cycle B applies AddRoundKey (and InvMixColumns in ROUND) and updates the state register.
  - `rk_idx` is held for both cycles.
  - Accept-to-`out_valid` latency is 21 cycles.
- Macro undefined: single-cycle rounds, 11-cycle latency as above.
- The macro does not change outputs, handshake rules or reset values.

## Test plan
- **FIPS-197 C.1:** key 000102030405060708090a0b0c0d0e0f with the matching 11-entry key store; `ciphertext` 69c4e0d86a7b0430d8cdb78070b4c55a → `plaintext` 00112233445566778899aabbccddeeff, `out_valid` at cycle 11 (21 with `AES_INV_SUBBYTE_REG_EN`).
- **Round-key sequence:** during the C.1 run, `rk_idx` reads 10 in the accept cycle, then 9,8,…,1 on consecutive ROUND cycles (each held 2 cycles with the macro), then 0 in FINAL and DONE.
- **Backpressure:** hold `out_ready` = 0 for 20 cycles after `out_valid` → `plaintext` stable, `in_ready` = 0, a new `in_valid` is ignored; release → IDLE next cycle; the new block completes correctly.
- **Back-to-back:** two blocks with `in_valid` and `out_ready` tied high → results in order, accepts spaced 12 cycles apart.
- **Reset mid-round:** assert `rst_n` = 0 at cycle 5 of a decryption → outputs at reset values asynchronously; after release, the C.1 vector decrypts correctly with no stale `out_valid`.
- **All-zero vector:** key 00…00, `ciphertext` 66e94bd4ef8a2c3b884cfa59ca342b2e → `plaintext` 00…00.
